fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction fetch sequencer for cpu_top.
//  - Owns the PC and reads 32-bit words from the flat instruction-memory image.
//  - Buffers fetched words in a small fetch queue.
//  - Presents them in order to decode over a valid/ready handshake.
//  - Handles redirects (branch/flush), back-pressure, and out-of-range or misaligned PC faults.
// PARAMETERS
//  IMEM_WORDS  256    words in instruction image; image width = IMEM_WORDS*32
//  FQ_DEPTH    4      fetch-queue entries (power of 2, >=2)
//  RESET_PC    32'h0  PC loaded on reset (byte address)
// PORTS
//  clk                 in   1              rising-edge clock
//  reset_n             in   1              asynchronous, active-low reset
//  instruction_memory  in   IMEM_WORDS*32  flat image; word i at [i*32 +: 32]
//  fetch_en            in   1              permit fetching
//  redirect_valid      in   1              flush queue and load redirect_pc
//  redirect_pc         in   32             new byte-address PC
//  out_valid           out  1              head entry valid toward decode
//  out_ready           in   1              decode accepts head entry
//  out_instr           out  32             head instruction word
//  out_pc              out  32             byte PC of head instruction
//  out_fault           out  1              head entry is a fetch fault
//  fq_count            out  $clog2(FQ_DEPTH+1)  occupied queue entries
//  halted              out  1              state == HALT
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - pc = RESET_PC, queue empty, state = IDLE.
//   - out_valid = 0; out_instr, out_pc, out_fault = 0; fq_count = 0; halted = 0.
//  Address decode:
//   - Word index = pc[31:2].
//   - Range fault: pc[31:2] >= IMEM_WORDS.
//   - Alignment fault: pc[1:0] != 0.
//  States:
//   - IDLE:  no enqueue. fetch_en=1 -> FETCH.
//   - FETCH: fetch_en=0 -> IDLE; queue is kept and continues to drain.
//     Each cycle with queue space, enqueue {pc, word, fault=0} and pc <= pc+4.
//     On a fault, enqueue one entry {pc, NOP_INSTR, fault=1}, pc unchanged, go to HALT.
//   - HALT: no enqueue; queue drains; halted = 1. Exit only on redirect.
//  Queue space:
//   - Space = fq_count < FQ_DEPTH, OR a pop occurs in the same cycle.
//   - Full + pop gives a simultaneous push and pop; fq_count is unchanged.
//  Pop: out_valid && out_ready; head advances at the edge.
//  Outputs: registered from queue head. out_valid = (fq_count != 0).
//  Latency: fetch_en high at edge k (IDLE->FETCH); first enqueue at edge k+1; out_valid high after edge k+1.
//  Redirect (highest priority, overrides push, pop, and fetch_en that cycle):
//   - Queue cleared, so out_valid = 0 after the edge.
//   - pc <= redirect_pc.
//   - Any pop that cycle is discarded; decode must not count it as accepted.
//   - Next state = fetch_en ? FETCH : IDLE, including from HALT.
//  Fault checks: a misaligned or out-of-range redirect_pc faults on its first fetch, not at redirect.
//  PC arithmetic: 32-bit, wraps mod 2^32; the range check catches overflow before any wrapped fetch.
//  Stalls: while out_valid && !out_ready, out_* are held stable.
//  Reset mid-operation: everything returns to reset values immediately; no partial entry survives.
// STRUCTURE
//  fetch_pkg (shared package):
//   - fq_entry_t struct {pc[31:0], instr[31:0], fault}
//   - fetch_state_t enum {IDLE, FETCH, HALT}
//   - NOP_INSTR = 32'h0000_0013
//  Sub-module fetch_queue:
//   - Synchronous FIFO of fq_entry_t, parameter FQ_DEPTH.
//   - Ports: push, pop, flush, count, head.
//   - Pointer wrap mod FQ_DEPTH; flush dominates push and pop.
//  fetch_ctrl holds the PC, FSM, fault detect, and word select.
// TESTING
//  1. Image words 0..7 = 32'h1000_0000+i; reset; fetch_en=1; out_ready=1.
//     -> out_pc 0,4,8,... in order with instr 1000_0000..1000_0007; one per cycle after a 2-cycle startup.
//  2. out_ready=0 for 10 cycles.
//     -> fq_count saturates at 4; pc stops at 16; head stays pc 0 / instr 1000_0000.
//     Release -> pcs 0..28 delivered with no gap or duplicate.
//  3. Queue holds pc 8,12,16; redirect_valid=1, redirect_pc=32'h40, same cycle as out_ready=1.
//     -> next cycle out_valid=0; next delivered pc is 0x40 with word 16; pc 8 is never accepted.
//  4. Redirect to 32'h3FC (last word), then let fetch run.
//     -> deliver pc 0x3FC normally; then pc 0x400 with fault=1, instr 0000_0013; halted=1; no further entries.
//  5. In HALT, redirect to 32'h2 (misaligned).
//     -> fault entry at pc 2; remains HALT.
//     Redirect to 0 -> halted=0 and normal fetch resumes.
//  6. Assert reset_n=0 mid-stream (asynchronously, between edges).
//     -> out_valid=0 and fq_count=0 immediately.
//     After release with fetch_en=1 -> first pc delivered = RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Types and constants shared by the instruction fetch sequencer, its fetch
//   queue and the decode-side interface.
//   - fq_entry_t    : one fetch-queue entry {pc, instr, fault}
//   - fetch_state_t : sequencer FSM states
//   - NOP_INSTR     : word presented for a faulting fetch
//   - pc_fault()    : misalignment / out-of-image check for a byte PC
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fq_entry_t;

    // A PC faults when it is not word aligned or its word index lies past the
    // end of the image. Because the index is taken from the full pc[31:2], a
    // PC that wrapped past 2^32 is always caught here before it is fetched.
    function automatic logic pc_fault(input logic [31:0] pc,
                                      input logic [29:0] word_limit);
        return (pc[1:0] != 2'b00) || (pc[31:2] >= word_limit);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//   Valid/ready channel from the fetch sequencer to decode.
//   out_valid  : head entry valid toward decode
//   out_ready  : decode accepts the head entry this cycle
//   out_instr  : head instruction word
//   out_pc     : byte PC of the head instruction
//   out_fault  : head entry is a fetch fault (instr is a NOP)
//   master = fetch side, slave = decode side.
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        output out_fault,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_fault,
        output out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Synchronous FIFO of fq_entry_t, FQ_DEPTH entries (power of 2, >= 2).
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : enqueue din (accepted when not full, or full with a pop)
//   pop          : dequeue head (ignored when empty)
//   flush        : clear the queue; dominates push and pop
//   count        : occupied entries
//   head         : entry at the read pointer (all-zero after reset)
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int FQ_DEPTH = 4,
    localparam int CW       = $clog2(FQ_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  fq_entry_t     din,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fq_entry_t     head
);

    localparam int            PW      = $clog2(FQ_DEPTH);
    localparam logic [CW-1:0] FQ_FULL = CW'(FQ_DEPTH);

    fq_entry_t         mem [FQ_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;

    // Full + pop still accepts a push: the slot freed by the pop is reused
    // in the same edge, so count stays put.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FQ_FULL) || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction fetch sequencer. Owns the PC, reads 32-bit words from a flat
//   instruction image, buffers them in fetch_queue and presents them in order
//   to decode. Handles redirects, back-pressure and PC faults.
//   clk                : rising-edge clock
//   reset_n            : asynchronous active-low reset
//   instruction_memory : flat image, word i at [i*32 +: 32]
//   fetch_en           : permit fetching
//   redirect_valid     : flush queue and load redirect_pc (highest priority)
//   redirect_pc        : new byte-address PC
//   dec                : decode channel (fetch_ctrl_if.master)
//   fq_count           : occupied queue entries
//   halted             : sequencer is in HALT
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter  int          IMEM_WORDS = 256,
    parameter  int          FQ_DEPTH   = 4,
    parameter  logic [31:0] RESET_PC   = 32'h0,
    localparam int          CW         = $clog2(FQ_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [IMEM_WORDS*32-1:0] instruction_memory,
    input  logic                    fetch_en,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    fetch_ctrl_if.master            dec,
    output logic [CW-1:0]           fq_count,
    output logic                    halted
);

    localparam int            AW         = $clog2(IMEM_WORDS);
    localparam logic [29:0]   IMEM_LIMIT = 30'(IMEM_WORDS);
    localparam logic [CW-1:0] FQ_FULL    = CW'(FQ_DEPTH);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  imem [IMEM_WORDS];
    logic [AW-1:0] widx;
    logic [31:0]  word;
    logic         cur_fault;
    logic         pop;
    logic         space;
    logic         push;
    fq_entry_t    push_entry;
    fq_entry_t    head;

    // Word select. The index is only meaningful when cur_fault is low, so
    // the truncated pc bits are safe to use unconditionally.
    for (genvar i = 0; i < IMEM_WORDS; i++) begin : g_word
        assign imem[i] = instruction_memory[i*32 +: 32];
    end

    assign widx = pc[AW+1:2];
    assign word = imem[widx];

    always_comb begin
        cur_fault        = pc_fault(pc, IMEM_LIMIT);
        pop              = dec.out_valid && dec.out_ready;
        space            = (fq_count != FQ_FULL) || pop;
        push             = (state == FETCH) && fetch_en && space && !redirect_valid;
        push_entry.pc    = pc;
        push_entry.instr = cur_fault ? NOP_INSTR : word;
        push_entry.fault = cur_fault;
    end

    // The queue sees the raw pop; flush (redirect) dominates inside it, so a
    // pop coinciding with a redirect is discarded.
    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (push_entry),
        .pop     (pop),
        .flush   (redirect_valid),
        .count   (fq_count),
        .head    (head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else if (redirect_valid) begin
            // Fault checks on the new PC happen at its first fetch.
            pc     <= redirect_pc;
            state  <= fetch_en ? FETCH : IDLE;
            halted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en) state <= FETCH;
                end
                FETCH: begin
                    if (!fetch_en) begin
                        state <= IDLE;
                    end else if (space) begin
                        if (cur_fault) begin
                            // The fault entry is the last one; PC stays on it.
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state  <= IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    assign dec.out_valid = (fq_count != '0);
    assign dec.out_pc    = head.pc;
    assign dec.out_instr = head.instr;
    assign dec.out_fault = head.fault;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int          IMEM_WORDS = 256;
    localparam int          FQ_DEPTH   = 4;
    localparam logic [31:0] RESET_PC   = 32'h0;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b1;
    logic [IMEM_WORDS*32-1:0] imem_bus;
    logic                    fetch_en = 1'b0;
    logic                    redirect_valid = 1'b0;
    logic [31:0]             redirect_pc = 32'h0;
    logic [2:0]              fq_count;
    logic                    halted;

    fetch_ctrl_if dec();

    fetch_ctrl #(
        .IMEM_WORDS (IMEM_WORDS),
        .FQ_DEPTH   (FQ_DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .instruction_memory (imem_bus),
        .fetch_en           (fetch_en),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .dec                (dec),
        .fq_count           (fq_count),
        .halted             (halted)
    );

    always #5 clk = ~clk;

    logic [31:0] img [IMEM_WORDS];
    int checks = 0;
    int failures = 0;

    // Reference model: a plain queue of expected entries, the PC, and a mode
    // (0 idle, 1 fetching, 2 halted), advanced once per clock edge.
    fq_entry_t   mq[$];
    logic [31:0] mpc;
    int          mstate;

    task automatic model_reset();
        mq.delete();
        mpc    = RESET_PC;
        mstate = 0;
    endtask

    task automatic model_step();
        int        sz = mq.size();
        bit        popped;
        fq_entry_t e;
        if (!reset_n) return;
        if (redirect_valid) begin
            mq.delete();
            mpc    = redirect_pc;
            mstate = fetch_en ? 1 : 0;
            return;
        end
        popped = (sz != 0) && dec.out_ready;
        if (popped) void'(mq.pop_front());
        if (mstate == 0) begin
            if (fetch_en) mstate = 1;
        end else if (mstate == 1) begin
            if (!fetch_en) begin
                mstate = 0;
            end else if (sz < FQ_DEPTH || popped) begin
                e.pc = mpc;
                if ((mpc % 4 != 0) || (mpc / 4 >= IMEM_WORDS)) begin
                    e.instr = NOP_INSTR;
                    e.fault = 1'b1;
                    mstate  = 2;
                end else begin
                    e.instr = img[mpc[9:2]];
                    e.fault = 1'b0;
                    mpc     = mpc + 32'd4;
                end
                mq.push_back(e);
            end
        end
    endtask

    // Advance model and DUT by one edge; return #1 after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec.out_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dec.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dec.out_valid); end
        checks++; if (dec.out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", dec.out_instr); end
        checks++; if (dec.out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", dec.out_pc); end
        checks++; if (dec.out_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", dec.out_fault); end
        checks++; if (fq_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fq_count); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    endtask

    task automatic test_stream();
        do_reset();
        fetch_en      = 1'b1;
        dec.out_ready = 1'b1;
        tick();
        checks++; if (dec.out_valid !== 1'b0) begin failures++; $display("FAIL stream_startup got=%b exp=0", dec.out_valid); end
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++; if (dec.out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, dec.out_valid); end
            checks++; if (dec.out_pc !== 32'(4*i)) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, dec.out_pc, 32'(4*i)); end
            checks++; if (dec.out_instr !== 32'h1000_0000 + 32'(i)) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, dec.out_instr, 32'h1000_0000 + 32'(i)); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_en      = 1'b1;
        dec.out_ready = 1'b0;
        repeat (10) tick();
        checks++; if (fq_count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", fq_count); end
        checks++; if (dec.out_pc !== 32'h0) begin failures++; $display("FAIL bp_head_pc got=%h exp=0", dec.out_pc); end
        checks++; if (dec.out_instr !== 32'h1000_0000) begin failures++; $display("FAIL bp_head_instr got=%h exp=10000000", dec.out_instr); end
        dec.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (dec.out_valid !== 1'b1 || dec.out_pc !== 32'(4*i)) begin failures++; $display("FAIL bp_release[%0d] valid=%b pc=%h exp_pc=%h", i, dec.out_valid, dec.out_pc, 32'(4*i)); end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en      = 1'b1;
        dec.out_ready = 1'b0;
        repeat (5) tick();
        dec.out_ready = 1'b1;
        repeat (2) tick();
        checks++; if (dec.out_pc !== 32'h8) begin failures++; $display("FAIL redir_pre_head got=%h exp=8", dec.out_pc); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        checks++; if (dec.out_valid !== 1'b0 || fq_count !== 3'd0) begin failures++; $display("FAIL redir_flush valid=%b count=%0d exp 0/0", dec.out_valid, fq_count); end
        tick();
        checks++; if (dec.out_valid !== 1'b1 || dec.out_pc !== 32'h40) begin failures++; $display("FAIL redir_target valid=%b pc=%h exp pc=40", dec.out_valid, dec.out_pc); end
        checks++; if (dec.out_instr !== img[16]) begin failures++; $display("FAIL redir_instr got=%h exp=%h", dec.out_instr, img[16]); end
    endtask

    task automatic test_range_fault();
        fetch_en       = 1'b1;
        dec.out_ready  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3FC;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (dec.out_pc !== 32'h3FC || dec.out_fault !== 1'b0) begin failures++; $display("FAIL last_word pc=%h fault=%b exp 3fc/0", dec.out_pc, dec.out_fault); end
        checks++; if (dec.out_instr !== img[255]) begin failures++; $display("FAIL last_word_instr got=%h exp=%h", dec.out_instr, img[255]); end
        tick();
        checks++; if (dec.out_valid !== 1'b1 || dec.out_pc !== 32'h400 || dec.out_fault !== 1'b1) begin failures++; $display("FAIL range_fault valid=%b pc=%h fault=%b exp 1/400/1", dec.out_valid, dec.out_pc, dec.out_fault); end
        checks++; if (dec.out_instr !== NOP_INSTR) begin failures++; $display("FAIL range_fault_instr got=%h exp=%h", dec.out_instr, NOP_INSTR); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL range_halted got=%b exp=1", halted); end
        repeat (4) tick();
        checks++; if (dec.out_valid !== 1'b0 || fq_count !== 3'd0 || halted !== 1'b1) begin failures++; $display("FAIL halt_drain valid=%b count=%0d halted=%b exp 0/0/1", dec.out_valid, fq_count, halted); end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (dec.out_pc !== 32'h2 || dec.out_fault !== 1'b1) begin failures++; $display("FAIL misalign_entry pc=%h fault=%b exp 2/1", dec.out_pc, dec.out_fault); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL misalign_halted got=%b exp=1", halted); end
        repeat (3) tick();
        checks++; if (dec.out_valid !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL misalign_stay valid=%b halted=%b exp 0/1", dec.out_valid, halted); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL resume_halted got=%b exp=0", halted); end
        tick();
        checks++; if (dec.out_pc !== 32'h0 || dec.out_fault !== 1'b0 || dec.out_instr !== img[0]) begin failures++; $display("FAIL resume_entry pc=%h fault=%b instr=%h exp 0/0/%h", dec.out_pc, dec.out_fault, dec.out_instr, img[0]); end
    endtask

    task automatic test_async_reset();
        fetch_en      = 1'b1;
        dec.out_ready = 1'b0;
        repeat (4) tick();
        #3 reset_n = 1'b0;
        #1;
        checks++; if (dec.out_valid !== 1'b0 || fq_count !== 3'd0) begin failures++; $display("FAIL async_reset valid=%b count=%0d exp 0/0", dec.out_valid, fq_count); end
        model_reset();
        dec.out_ready = 1'b1;
        @(posedge clk);
        #2 reset_n = 1'b1;
        tick();
        tick();
        checks++; if (dec.out_valid !== 1'b1 || dec.out_pc !== RESET_PC) begin failures++; $display("FAIL post_reset_pc valid=%b pc=%h exp 1/%h", dec.out_valid, dec.out_pc, RESET_PC); end
    endtask

    task automatic test_random();
        int r;
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks++; if (dec.out_valid !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", cyc, dec.out_valid, mq.size() != 0); end
            checks++; if (int'(fq_count) !== mq.size()) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", cyc, fq_count, mq.size()); end
            checks++; if (halted !== (mstate == 2)) begin failures++; $display("FAIL rnd_halted[%0d] got=%b exp=%b", cyc, halted, mstate == 2); end
            if (mq.size() != 0) begin
                checks++;
                if (dec.out_pc !== mq[0].pc || dec.out_instr !== mq[0].instr || dec.out_fault !== mq[0].fault) begin
                    failures++;
                    $display("FAIL rnd_head[%0d] got=%h/%h/%b exp=%h/%h/%b", cyc, dec.out_pc, dec.out_instr, dec.out_fault, mq[0].pc, mq[0].instr, mq[0].fault);
                end
            end
            fetch_en       = ($urandom_range(0, 9) != 0);
            dec.out_ready  = ($urandom_range(0, 4) < 3);
            redirect_valid = ($urandom_range(0, 19) == 0);
            r = int'($urandom_range(0, 5));
            case (r)
                0, 1:    redirect_pc = 32'($urandom_range(0, 255)) << 2;
                2:       redirect_pc = 32'h3F0 + (32'($urandom_range(0, 3)) << 2);
                3:       redirect_pc = 32'($urandom_range(0, 1023));
                4:       redirect_pc = 32'hFFFF_FFFC;
                default: redirect_pc = 32'h400;
            endcase
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) begin
            img[i] = (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom();
            imem_bus[i*32 +: 32] = img[i];
        end
        dec.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_range_fault();
        test_misaligned();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
